quick_sort_engine: RTL and testbench

Parametrised in-place quicksort controller, the next generation of the fixed 16-bit sorter. It sorts a contiguous segment of an external synchronous RAM, addressed as `base + index`, using Lomuto partitioning and an internal explicit segment stack. The controller adds a start/busy/done handshake, a selectable sort direction, a stack-overflow error and bounded stack growth. It sits between the system controller and the shared data RAM, and owns the RAM port while busy.

---
 rtl/quick_sort_engine.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_quick_sort_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_sort_engine.sv
// rtl/quick_sort_engine.sv - in-place Lomuto quicksort controller over an external synchronous RAM
module quick_sort_engine #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 descending,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W-1:0]    lo,
  input  logic [ADDR_W-1:0]    hi,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W:0] ONE_X = 1;

  typedef enum logic [4:0] {
    S_IDLE, S_INIT, S_POP, S_RD_PIV, S_PIV_CAP, S_RD_J, S_CMP,
    S_SW_RD, S_SW_CAP, S_SW_WI, S_SW_WJ,
    S_FIN_RD, S_FIN_CAP, S_FIN_WI, S_FIN_WH,
    S_PUSH_A, S_PUSH_B, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]    base_r, seg_l, seg_h, idx_i, idx_j, j_inc;
  logic                 desc_r;
  logic [WORD_SIZE-1:0] pivot, val_r, tmp_r;

  // Segment stack; entries above sp are don't-care, so storage needs no reset
  logic [ADDR_W-1:0] stk_lo [1<<IDX_W];
  logic [ADDR_W-1:0] stk_hi [1<<IDX_W];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  top_idx, wr_idx;
  logic              stk_full, stk_empty;

  // Control outputs of the next-state logic
  logic              push_en, pop_en, ovf;
  logic [ADDR_W-1:0] push_l, push_h;
  logic              rd_nxt, wr_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic [WORD_SIZE-1:0] wdata_nxt;

  // Partition result guards, widened one bit so i-1 / i+1 never wrap
  logic [ADDR_W:0] i_x, l_x, h_x, left_sz, right_sz;
  logic            left_ok, right_ok, left_first, take_swap;

  assign top_idx   = IDX_W'(sp - 1'b1);
  assign wr_idx    = IDX_W'(sp);
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign j_inc     = idx_j + 1'b1;

  assign i_x        = {1'b0, idx_i};
  assign l_x        = {1'b0, seg_l};
  assign h_x        = {1'b0, seg_h};
  assign left_ok    = (i_x > l_x + ONE_X);
  assign right_ok   = (i_x + ONE_X < h_x);
  assign left_sz    = i_x - l_x;
  assign right_sz   = h_x - i_x;
  assign left_first = (left_sz >= right_sz);
  assign take_swap  = desc_r ? (mem_rdata > pivot) : (mem_rdata < pivot);
  assign ovf        = push_en && stk_full;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus look-ahead RAM strobes for the state being entered
  always_comb begin
    state_nxt = state;
    push_en   = 1'b0;
    push_l    = '0;
    push_h    = '0;
    pop_en    = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    idx_nxt   = '0;
    wdata_nxt = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: begin
        if (seg_l < seg_h) begin
          push_en   = 1'b1;
          push_l    = seg_l;
          push_h    = seg_h;
          state_nxt = S_POP;
        end else begin
          state_nxt = S_FINISH;
        end
      end
      S_POP: begin
        if (stk_empty) begin
          state_nxt = S_FINISH;
        end else begin
          pop_en    = 1'b1;
          rd_nxt    = 1'b1;
          idx_nxt   = stk_hi[top_idx];
          state_nxt = S_RD_PIV;
        end
      end
      S_RD_PIV: state_nxt = S_PIV_CAP;
      S_PIV_CAP: begin
        rd_nxt    = (seg_l != seg_h);
        idx_nxt   = seg_l;
        state_nxt = S_RD_J;
      end
      S_RD_J: begin
        if (idx_j == seg_h) begin
          rd_nxt    = 1'b1;
          idx_nxt   = idx_i;
          state_nxt = S_FIN_RD;
        end else begin
          state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (take_swap) begin
          rd_nxt    = 1'b1;
          idx_nxt   = idx_i;
          state_nxt = S_SW_RD;
        end else begin
          rd_nxt    = (j_inc != seg_h);
          idx_nxt   = j_inc;
          state_nxt = S_RD_J;
        end
      end
      S_SW_RD: state_nxt = S_SW_CAP;
      S_SW_CAP: begin
        wr_nxt    = 1'b1;
        idx_nxt   = idx_i;
        wdata_nxt = val_r;
        state_nxt = S_SW_WI;
      end
      S_SW_WI: begin
        wr_nxt    = 1'b1;
        idx_nxt   = idx_j;
        wdata_nxt = tmp_r;
        state_nxt = S_SW_WJ;
      end
      S_SW_WJ: begin
        rd_nxt    = (j_inc != seg_h);
        idx_nxt   = j_inc;
        state_nxt = S_RD_J;
      end
      S_FIN_RD: state_nxt = S_FIN_CAP;
      S_FIN_CAP: begin
        wr_nxt    = 1'b1;
        idx_nxt   = idx_i;
        wdata_nxt = pivot;
        state_nxt = S_FIN_WI;
      end
      S_FIN_WI: begin
        wr_nxt    = 1'b1;
        idx_nxt   = seg_h;
        wdata_nxt = tmp_r;
        state_nxt = S_FIN_WH;
      end
      S_FIN_WH: state_nxt = (left_ok || right_ok) ? S_PUSH_A : S_POP;
      S_PUSH_A: begin
        push_en = 1'b1;
        if (left_ok && (!right_ok || left_first)) begin
          push_l = seg_l;
          push_h = idx_i - 1'b1;
        end else begin
          push_l = idx_i + 1'b1;
          push_h = seg_h;
        end
        state_nxt = (left_ok && right_ok) ? S_PUSH_B : S_POP;
      end
      S_PUSH_B: begin
        push_en = 1'b1;
        if (left_first) begin
          push_l = idx_i + 1'b1;
          push_h = seg_h;
        end else begin
          push_l = seg_l;
          push_h = idx_i - 1'b1;
        end
        state_nxt = S_POP;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (ovf) state_nxt = S_FINISH;
  end

  // Stack pointer; cleared on each accepted start so an aborted sort leaves no residue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    sp <= '0;
    else if (state == S_IDLE && start) sp <= '0;
    else if (push_en && !stk_full)   sp <= sp + 1'b1;
    else if (pop_en)                 sp <= sp - 1'b1;
  end

  // Stack storage
  always_ff @(posedge clk) begin
    if (push_en && !stk_full) begin
      stk_lo[wr_idx] <= push_l;
      stk_hi[wr_idx] <= push_h;
    end
  end

  // Datapath: latched request, current segment, scan indices and captured words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r <= '0;
      seg_l  <= '0;
      seg_h  <= '0;
      idx_i  <= '0;
      idx_j  <= '0;
      desc_r <= 1'b0;
      pivot  <= '0;
      val_r  <= '0;
      tmp_r  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base_r <= base;
          seg_l  <= lo;
          seg_h  <= hi;
          desc_r <= descending;
        end
        S_POP: if (pop_en) begin
          seg_l <= stk_lo[top_idx];
          seg_h <= stk_hi[top_idx];
        end
        S_PIV_CAP: begin
          pivot <= mem_rdata;
          idx_i <= seg_l;
          idx_j <= seg_l;
        end
        S_CMP: begin
          val_r <= mem_rdata;
          if (!take_swap) idx_j <= j_inc;
        end
        S_SW_CAP:  tmp_r <= mem_rdata;
        S_SW_WJ: begin
          idx_i <= idx_i + 1'b1;
          idx_j <= j_inc;
        end
        S_FIN_CAP: tmp_r <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Registered RAM port and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_rd_en <= rd_nxt;
      mem_wr_en <= wr_nxt;
      if (rd_nxt || wr_nxt) mem_addr <= base_r + idx_nxt;
      if (wr_nxt) mem_wdata <= wdata_nxt;
      done <= (state == S_FINISH);
      if (state == S_INIT)        busy <= 1'b1;
      else if (state == S_FINISH) busy <= 1'b0;
      if (state == S_IDLE && start) err <= 1'b0;
      else if (ovf)                 err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quick_sort_engine.sv
// tb/tb_quick_sort_engine.sv - randomized self-checking bench against a queue-based quicksort model
module tb_quick_sort_engine;

  localparam int WS = 16;
  localparam int AW = 16;
  localparam int SD = 2;

  logic          clk = 1'b0;
  logic          reset_n, start, descending;
  logic [AW-1:0] base, lo, hi;
  logic          busy, done, err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [WS-1:0] mem_wdata, mem_rdata;

  logic [WS-1:0] ram [0:65535];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [WS-1:0] ld_data;

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;
  int n_checks = 0, n_errs = 0;

  logic [WS-1:0] init_a [64];
  logic [WS-1:0] ref_a  [64];
  int m_err, m_cycles, m_writes, m_reads;

  always #5 clk = ~clk;

  quick_sort_engine #(.WORD_SIZE(WS), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .descending(descending),
    .base(base), .lo(lo), .hi(hi), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wr_en)  ram[mem_addr] <= mem_wdata;
    else if (ld_en) ram[ld_addr] <= ld_data;
    if (mem_rd_en)  mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Quicksort as written in prose: Lomuto scan, larger-first pushes, bounded stack
  task automatic model_sort(input int l0, input int h0, input bit d);
    int sl[$];
    int sh[$];
    int L, H, i, nseg;
    int pl[2];
    int ph[2];
    logic [WS-1:0] piv, t;
    m_err = 0; m_cycles = 1; m_writes = 0; m_reads = 0;
    if (l0 >= h0) begin
      m_cycles += 1;
      return;
    end
    sl.push_back(l0); sh.push_back(h0);
    forever begin
      m_cycles += 1;
      if (sl.size() == 0) begin
        m_cycles += 1;
        return;
      end
      L = sl.pop_back(); H = sh.pop_back();
      m_cycles += 2; m_reads += 1;
      piv = ref_a[H]; i = L;
      for (int j = L; j < H; j++) begin
        m_cycles += 2; m_reads += 1;
        if (d ? (ref_a[j] > piv) : (ref_a[j] < piv)) begin
          t = ref_a[i]; ref_a[i] = ref_a[j]; ref_a[j] = t;
          i++;
          m_cycles += 4; m_reads += 1; m_writes += 2;
        end
      end
      m_cycles += 5; m_reads += 1; m_writes += 2;
      t = ref_a[i]; ref_a[i] = piv; ref_a[H] = t;
      nseg = 0;
      if (i > L + 1 && i + 1 < H) begin
        if (i - L >= H - i) begin pl = '{L, i + 1}; ph = '{i - 1, H}; end
        else                begin pl = '{i + 1, L}; ph = '{H, i - 1}; end
        nseg = 2;
      end else if (i > L + 1) begin
        pl[0] = L; ph[0] = i - 1; nseg = 1;
      end else if (i + 1 < H) begin
        pl[0] = i + 1; ph[0] = H; nseg = 1;
      end
      for (int s = 0; s < nseg; s++) begin
        m_cycles += 1;
        if (sl.size() == SD) begin
          m_err = 1;
          m_cycles += 1;
          return;
        end
        sl.push_back(pl[s]); sh.push_back(ph[s]);
      end
    end
  endtask

  task automatic load_ram(input logic [AW-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      ld_en = 1'b1; ld_addr = b + AW'(k); ld_data = init_a[k];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "/busy"}, busy, 0);
    check_val({tag, "/done"}, done, 0);
    check_val({tag, "/err"}, err, 0);
    check_val({tag, "/rd_en"}, mem_rd_en, 0);
    check_val({tag, "/wr_en"}, mem_wr_en, 0);
    check_val({tag, "/addr"}, mem_addr, 0);
    check_val({tag, "/wdata"}, mem_wdata, 0);
  endtask

  task automatic run_case(input string tag, input logic [AW-1:0] b, input int l, input int h,
                          input bit d, input int n, input bit poke);
    int cyc, rd0, wr0, both0, done0;
    bit got;
    logic busy1;
    logic [AW-1:0] a;
    load_ram(b, n);
    for (int k = 0; k < 64; k++) ref_a[k] = init_a[k];
    model_sort(l, h, d);
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt; done0 = done_cnt;
    base = b; lo = AW'(l); hi = AW'(h); descending = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; got = 1'b0; busy1 = 1'b0;
    while (!got && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (poke && cyc == 4) begin start = 1'b1; lo = '0; hi = AW'(3); end
      if (poke && cyc == 5) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check_val({tag, "/done_seen"}, got, 1);
    check_val({tag, "/latency"}, cyc, m_cycles);
    check_val({tag, "/busy_first"}, busy1, 1);
    check_val({tag, "/busy_at_done"}, busy, 0);
    check_val({tag, "/err"}, err, m_err);
    repeat (4) begin @(posedge clk); #1; end
    check_val({tag, "/done_pulses"}, done_cnt - done0, 1);
    check_val({tag, "/err_held"}, err, m_err);
    check_val({tag, "/reads"}, rd_cnt - rd0, m_reads);
    check_val({tag, "/writes"}, wr_cnt - wr0, m_writes);
    check_val({tag, "/both_strobes"}, both_cnt - both0, 0);
    for (int k = 0; k < n; k++) begin
      a = b + AW'(k);
      check_val($sformatf("%s/ram[%0d]", tag, k), ram[a], ref_a[k]);
    end
  endtask

  task automatic check_ram_const(input string tag, input logic [AW-1:0] b, input int exp_v[], input int n);
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      a = b + AW'(k);
      check_val($sformatf("%s/const[%0d]", tag, k), ram[a], exp_v[k]);
    end
  endtask

  initial begin
    int exp_v[];
    int done0;
    reset_n = 1'b0; start = 1'b0; descending = 1'b0;
    base = '0; lo = '0; hi = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    init_a[0:7] = '{16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4};
    run_case("asc8", 16'h0040, 0, 7, 1'b0, 8, 1'b0);
    exp_v = '{1, 2, 3, 4, 5, 7, 8, 9};
    check_ram_const("asc8", 16'h0040, exp_v, 8);

    init_a[0:7] = '{16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4};
    run_case("desc8", 16'h0080, 0, 7, 1'b1, 8, 1'b0);
    exp_v = '{9, 8, 7, 5, 4, 3, 2, 1};
    check_ram_const("desc8", 16'h0080, exp_v, 8);

    for (int k = 0; k < 8; k++) init_a[k] = 16'd6;
    run_case("equal8", 16'h00C0, 0, 7, 1'b0, 8, 1'b0);

    for (int k = 0; k < 16; k++) init_a[k] = WS'(k * 3);
    run_case("sorted16", 16'h0200, 0, 15, 1'b0, 16, 1'b0);

    init_a[0:2] = '{16'd3, 16'd2, 16'd1};
    run_case("wrap3", 16'hFFFE, 0, 2, 1'b0, 3, 1'b0);
    exp_v = '{1, 2, 3};
    check_ram_const("wrap3", 16'hFFFE, exp_v, 3);

    init_a[0:10] = '{16'd3, 16'd1, 16'd4, 16'd0, 16'd2, 16'd8, 16'd6, 16'd7, 16'd9, 16'd10, 16'd5};
    run_case("overflow", 16'h0300, 0, 10, 1'b0, 11, 1'b0);
    check_val("overflow/err_set", err, 1);

    init_a[0:1] = '{16'd2, 16'd1};
    run_case("after_ovf", 16'h0310, 0, 1, 1'b0, 2, 1'b0);
    check_val("after_ovf/err_clear", err, 0);

    for (int k = 0; k < 8; k++) init_a[k] = WS'(7 - k);
    run_case("lo_eq_hi", 16'h0400, 5, 5, 1'b0, 8, 1'b0);
    run_case("lo_gt_hi", 16'h0400, 6, 2, 1'b1, 8, 1'b0);

    for (int k = 0; k < 12; k++) init_a[k] = WS'($urandom_range(0, 50));
    run_case("start_busy", 16'h0500, 0, 11, 1'b0, 12, 1'b1);

    for (int k = 0; k < 16; k++) init_a[k] = WS'($urandom_range(0, 999));
    load_ram(16'h0100, 16);
    done0 = done_cnt;
    base = 16'h0100; lo = '0; hi = AW'(15); descending = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("mid_reset/no_done", done_cnt - done0, 0);
    run_case("after_reset", 16'h0100, 0, 15, 1'b0, 16, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int n, l, h;
      bit d;
      logic [AW-1:0] b;
      n = $urandom_range(2, 28);
      l = $urandom_range(0, 1);
      h = n - 1 - $urandom_range(0, 1);
      d = 1'($urandom_range(0, 1));
      b = AW'($urandom);
      for (int k = 0; k < n; k++)
        init_a[k] = (t % 2 == 1) ? WS'($urandom) : WS'($urandom_range(0, 5));
      run_case($sformatf("rand%0d", t), b, l, h, d, n, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
